// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - two-player ball game sequencer: serve timing, scoring, pause and game-over
module game_ctrl #(
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       pause_btn,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic       ball_enable,
   output logic       ball_reset,
   output logic       serve_dir,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic       game_over,
   output logic       winner
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      PAUSE = 3'd3,
      POINT = 3'd4,
      OVER  = 3'd5
   } state_t;

   localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
   localparam logic [7:0] SERVE_VAL = 8'(SERVE_FRAMES);

   state_t     state_q, state_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic [3:0] p1_q, p1_d;
   logic [3:0] p2_q, p2_d;
   logic       serve_dir_q, serve_dir_d;
   logic       winner_q, winner_d;
   logic       start_hist_q, pause_hist_q;

   logic       start_press;
   logic       pause_press;
   logic [7:0] frame_cnt_inc;

   assign start_press   = start_btn & ~start_hist_q;
   assign pause_press   = pause_btn & ~pause_hist_q;
   assign frame_cnt_inc = frame_cnt_q + 8'd1;

   // Next-state and datapath: every register update is decided here from the current state
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;
      case (state_q)
         IDLE: begin
            if (start_press) begin
               p1_d        = 4'd0;
               p2_d        = 4'd0;
               serve_dir_d = 1'b0;
               frame_cnt_d = 8'd0;
               state_d     = SERVE;
            end
         end
         SERVE: begin
            if (frame_tick) begin
               frame_cnt_d = frame_cnt_inc;
               if (frame_cnt_inc == SERVE_VAL) begin
                  state_d = PLAY;
               end
            end
         end
         PLAY: begin
            // Left miss wins over a simultaneous right miss; any miss swallows a pause press
            if (miss_left) begin
               if (p2_q < WIN_VAL) begin
                  p2_d = p2_q + 4'd1;
               end
               serve_dir_d = 1'b0;
               state_d     = POINT;
            end else if (miss_right) begin
               if (p1_q < WIN_VAL) begin
                  p1_d = p1_q + 4'd1;
               end
               serve_dir_d = 1'b1;
               state_d     = POINT;
            end else if (pause_press) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (pause_press) begin
               state_d = PLAY;
            end
         end
         POINT: begin
            if ((p1_q == WIN_VAL) || (p2_q == WIN_VAL)) begin
               winner_d = (p2_q == WIN_VAL);
               state_d  = OVER;
            end else begin
               frame_cnt_d = 8'd0;
               state_d     = SERVE;
            end
         end
         OVER: begin
            if (start_press) begin
               p1_d        = 4'd0;
               p2_d        = 4'd0;
               winner_d    = 1'b0;
               serve_dir_d = 1'b0;
               frame_cnt_d = 8'd0;
               state_d     = SERVE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; button history resets high so a held button is not a press
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         frame_cnt_q  <= 8'd0;
         p1_q         <= 4'd0;
         p2_q         <= 4'd0;
         serve_dir_q  <= 1'b0;
         winner_q     <= 1'b0;
         start_hist_q <= 1'b1;
         pause_hist_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         p1_q         <= p1_d;
         p2_q         <= p2_d;
         serve_dir_q  <= serve_dir_d;
         winner_q     <= winner_d;
         start_hist_q <= start_btn;
         pause_hist_q <= pause_btn;
      end
   end

   assign ball_enable = (state_q == PLAY);
   assign ball_reset  = (state_q == IDLE) || (state_q == SERVE) || (state_q == POINT);
   assign game_over   = (state_q == OVER);
   assign serve_dir   = serve_dir_q;
   assign p1_score    = p1_q;
   assign p2_score    = p2_q;
   assign winner      = winner_q;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Parameters
REQ-001 SHALL have parameter WIN_SCORE, default 9: score value that ends the game (legal range 1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60: frame_tick pulses counted in SERVE before play starts (legal range 1..255).

Interface
REQ-003 SHALL have port clk, input, 1 bit: single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port frame_tick, input, 1 bit: one-cycle pulse, once per video frame.
REQ-006 SHALL have port start_btn, input, 1 bit: start button, already synchronized and debounced.
REQ-007 SHALL have port pause_btn, input, 1 bit: pause button, already synchronized and debounced.
REQ-008 SHALL have port miss_left, input, 1 bit: pulse meaning Player 1 missed the ball.
REQ-009 SHALL have port miss_right, input, 1 bit: pulse meaning Player 2 missed the ball.
REQ-010 SHALL have port ball_enable, output, 1 bit: ball motion is permitted.
REQ-011 SHALL have port ball_reset, output, 1 bit: hold the ball at centre.
REQ-012 SHALL have port serve_dir, output, 1 bit: 0 = serve toward P1 (left), 1 = serve toward P2 (right).
REQ-013 SHALL have port p1_score, output, 4 bits: Player 1 score.
REQ-014 SHALL have port p2_score, output, 4 bits: Player 2 score.
REQ-015 SHALL have port game_over, output, 1 bit: game has ended.
REQ-016 SHALL have port winner, output, 1 bit: 0 = P1 won, 1 = P2 won; valid only while game_over = 1.

Function
REQ-017 SHALL implement a state machine with states IDLE, SERVE, PLAY, PAUSE, POINT and OVER.
REQ-018 SHALL detect a button press as a rising edge: button high now and its previous-cycle register low.
REQ-019 SHALL drive ball_enable, ball_reset and game_over as decodes of the state register only:
- ball_enable = 1 in PLAY only.
- ball_reset = 1 in IDLE, SERVE and POINT.
- game_over = 1 in OVER only.
REQ-020 IDLE: a start press SHALL clear both scores, set serve_dir to 0 and move to SERVE.
REQ-021 SERVE: entry SHALL clear the 8-bit frame counter; each frame_tick increments it; the cycle the counter reaches SERVE_FRAMES, the state SHALL move to PLAY.
REQ-022 PLAY, miss_left = 1: p2_score SHALL increment, serve_dir SHALL become 0 and the state SHALL move to POINT, all on the same edge.
REQ-023 PLAY, miss_right = 1: p1_score SHALL increment, serve_dir SHALL become 1 and the state SHALL move to POINT, all on the same edge.
REQ-024 PLAY, miss_left and miss_right both 1 in the same cycle: only miss_left SHALL be acted on (P2 is credited).
REQ-025 PLAY: a miss SHALL take priority over a same-cycle pause press; the pause press is discarded.
REQ-026 PLAY, pause press with no miss: move to PAUSE. PAUSE, pause press: move to PLAY. Misses and start presses SHALL be ignored in PAUSE.
REQ-027 POINT lasts one cycle and then moves:
- to OVER if p1_score or p2_score equals WIN_SCORE; winner = 1 if p2_score equals WIN_SCORE, else 0;
- otherwise to SERVE.
REQ-028 Scores SHALL saturate at WIN_SCORE and never exceed it.
REQ-029 Miss pulses outside PLAY SHALL be ignored.
REQ-030 Latency: a miss sampled at edge N SHALL give the updated score and ball_enable = 0 after edge N; ball_reset = 1 after edge N.
REQ-031 OVER: outputs SHALL hold; a start press SHALL clear both scores, clear winner, set serve_dir to 0 and move to SERVE.
REQ-032 frame_tick SHALL have no effect outside SERVE.

Reset
REQ-033 With reset_n = 0, asynchronously: state = IDLE, frame counter = 0, scores = 0, serve_dir = 0, winner = 0, game_over = 0, ball_enable = 0, ball_reset = 1.
REQ-034 Both button-history registers SHALL reset to 1, so a button held through reset release is not a press.
REQ-035 Reset asserted in any state, mid-serve or mid-pause included, SHALL abort the activity and return to IDLE with no score change carried over.

Verification
REQ-036 Reset release with start_btn held high -> stays IDLE; release and press start -> SERVE; after exactly 60 frame_ticks -> PLAY with ball_enable = 1.
REQ-037 In PLAY, miss_right pulse -> next cycle p1_score = 1, serve_dir = 1, ball_enable = 0; one cycle later state = SERVE.
REQ-038 In PLAY, miss_left and miss_right pulsed in the same cycle -> p2_score +1, p1_score unchanged, serve_dir = 0.
REQ-039 p2_score = 8 with WIN_SCORE = 9, miss_left -> p2_score = 9, then game_over = 1 and winner = 1; further misses change nothing; start press -> both scores 0, SERVE.
REQ-040 In PLAY, pause press -> PAUSE; miss_left pulses and frame_ticks ignored; second pause press -> PLAY with scores unchanged.
REQ-041 During SERVE at frame count 30, assert reset_n = 0 -> IDLE immediately; outputs match REQ-033.
